// File: rtl/soqpsk_pkg.sv
// Constants and types shared by the SOQPSK lookup-ROM arbiter and its requesters.
// The tag carries a granted read through the fixed ROM pipeline.
package soqpsk_pkg;

    localparam int LUT_AW      = 9;
    localparam int LUT_DW      = 14;
    localparam int LUT_DEPTH   = 512;
    localparam int LUT_ROM_LAT = 2;

    localparam int MAX_NREQ = 8;
    localparam int ID_W     = $clog2(MAX_NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } lut_tag_t;

endpackage : soqpsk_pkg

// File: rtl/rr_arbiter_core.sv
// Round-robin priority pick over NREQ level requests, plus the rotating pointer.
// The pointer moves one past the winner and holds on idle cycles.
module rr_arbiter_core
    import soqpsk_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_enable,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_gnt_any
);

    logic [ID_W-1:0]     r_ptr;
    logic [MAX_NREQ-1:0] w_req_ext;
    logic [MAX_NREQ-1:0] w_gnt_ext;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_found;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_cand;

    assign w_req_ext = MAX_NREQ'(i_req);

    // NOTE: every output of this block gets a default before the scan so no path
    // through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        w_gnt_ext = '0;
        w_gnt_id  = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        if (i_enable) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(NREQ)) begin
                    w_sum = w_sum - (ID_W+1)'(NREQ);
                end
                w_cand = w_sum[ID_W-1:0];
                if (!w_found && w_req_ext[w_cand]) begin
                    w_found           = 1'b1;
                    w_gnt_id          = w_cand;
                    w_gnt_ext[w_cand] = 1'b1;
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    assign o_gnt     = w_gnt_ext[NREQ-1:0];
    assign o_gnt_id  = w_gnt_id;
    assign o_gnt_any = w_found;

endmodule : rr_arbiter_core

// File: rtl/soqpsk_lut_arbiter.sv
// Shares one single-port SOQPSK lookup ROM between NREQ requesters, one read per
// clock, and returns each word to its requester with a one-hot valid strobe.
module soqpsk_lut_arbiter
    import soqpsk_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = LUT_AW,
    parameter int DW      = LUT_DW,
    parameter int ROM_LAT = LUT_ROM_LAT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_q,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data
);

    logic [NREQ-1:0] w_gnt;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_gnt_any;
    logic            w_enable;
    logic [AW-1:0]   w_rom_addr;
    logic [NREQ-1:0] w_rsp_valid;

    logic [AW-1:0]   r_last_addr;
    logic [DW-1:0]   r_rsp_data;
    lut_tag_t        r_tag [ROM_LAT+1];

    // Grants are suppressed while reset is asserted so gnt reads 0 during reset.
    assign w_enable = enable & reset_n;

    rr_arbiter_core #(
        .NREQ      (NREQ)
    ) u_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_enable  (w_enable),
        .i_req     (req),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    always_comb begin
        w_rom_addr = r_last_addr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_rom_addr = req_addr[i*AW +: AW];
            end
        end
    end

    // NOTE: the tag pipe is reset, unlike a plain data array, because its valid
    // bits must drop in-flight reads on reset; rsp_data resets to a known 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_rsp_data  <= '0;
            r_tag       <= '{default: '0};
        end else begin
            if (w_gnt_any) begin
                r_last_addr <= w_rom_addr;
            end
            r_tag[0] <= '{valid: w_gnt_any, id: w_gnt_id};
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            // rom_q carries the word for stage ROM_LAT-1 in this cycle.
            if (r_tag[ROM_LAT-1].valid) begin
                r_rsp_data <= rom_q;
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_valid[i] = r_tag[ROM_LAT].valid && (r_tag[ROM_LAT].id == ID_W'(i));
        end
    end

    assign gnt       = w_gnt;
    assign rom_addr  = w_rom_addr;
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule : soqpsk_lut_arbiter
